// File: rtl/fifo_arb_pkg.sv
// Shared types for the FIFO write arbiter.
//   arb_state_e : arbiter FSM states (IDLE, GRANT)
//   beat_t      : one FIFO write beat at the default geometry (PAR_WRITE x DATA_WIDTH)
package fifo_arb_pkg;

    localparam int unsigned DefDataWidth = 8;
    localparam int unsigned DefParWrite  = 4;
    // Wide enough for MAX_BURST up to 15.
    localparam int unsigned BurstCntW    = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    typedef logic [DefParWrite-1:0][DefDataWidth-1:0] beat_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin priority select.
//   req_i     : request vector, one bit per requester
//   last_id_i : previous owner; the search starts at last_id_i + 1 (mod NUM_REQ)
//   valid_o   : at least one request present
//   id_o      : index of the winning requester (0 when valid_o is low)
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    last_id_i,
    output logic               valid_o,
    output logic [ID_W-1:0]    id_o
);

    logic [ID_W-1:0] cand;

    always_comb begin
        valid_o = 1'b0;
        id_o    = '0;
        cand    = '0;
        // Offset NUM_REQ wraps back to last_id_i itself, so it has the lowest priority.
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand = ID_W'((32'(last_id_i) + off) % NUM_REQ);
            if (!valid_o && req_i[cand]) begin
                valid_o = 1'b1;
                id_o    = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter funnelling NUM_REQ requesters into one FIFO write port.
// A grant lasts until MAX_BURST beats are accepted or the owner drops req_valid.
// At most one beat is in flight, so peak throughput is one beat every two cycles.
//
// Ports:
//   clk, rst          : clock; asynchronous active-low reset
//   req_valid/data    : per-requester beat offer and payload
//   req_ready         : per-requester accept strobe (combinational)
//   fifo_ready        : FIFO can take one beat
//   fifo_data_in      : registered beat, held between writes
//   fifo_write_enable : one-cycle write strobe, the cycle after an accept
//   grant_id          : current owner
//   busy              : high while a grant is active
//   beat_count        : 16-bit wrapping count of write strobes; only present when
//                       FIFO_WRITE_ARBITER_STATS_EN is defined
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PAR_WRITE  = 4,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [NUM_REQ-1:0]                           req_valid,
    input  logic [NUM_REQ-1:0][PAR_WRITE-1:0][DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]                           req_ready,
    input  logic                                         fifo_ready,
    output logic [PAR_WRITE-1:0][DATA_WIDTH-1:0]         fifo_data_in,
    output logic                                         fifo_write_enable,
    output logic [$clog2(NUM_REQ)-1:0]                   grant_id,
`ifdef FIFO_WRITE_ARBITER_STATS_EN
    output logic [15:0]                                  beat_count,
`endif
    output logic                                         busy
);

    localparam int unsigned          IdW       = $clog2(NUM_REQ);
    localparam logic [BurstCntW-1:0] MaxBurst  = BurstCntW'(MAX_BURST);
    localparam logic [IdW-1:0]       LastIdRst = IdW'(NUM_REQ - 1);

    typedef logic [PAR_WRITE-1:0][DATA_WIDTH-1:0] word_beat_t;

    arb_state_e           state_q, state_d;
    logic [IdW-1:0]       grant_id_q, grant_id_d;
    logic [IdW-1:0]       last_id_q, last_id_d;
    logic [BurstCntW-1:0] burst_cnt_q, burst_cnt_d;
    logic                 we_q, we_d;
    word_beat_t           data_q, data_d;

    logic                 pick_valid;
    logic [IdW-1:0]       pick_id;
    logic                 accept;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (IdW)
    ) u_rr_picker (
        .req_i     (req_valid),
        .last_id_i (last_id_q),
        .valid_o   (pick_valid),
        .id_o      (pick_id)
    );

    // Blocking on we_q keeps a single beat in flight.
    assign accept = (state_q == GRANT) & req_valid[grant_id_q] & fifo_ready & ~we_q;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and grant bookkeeping
    always_comb begin
        state_d     = state_q;
        grant_id_d  = grant_id_q;
        last_id_d   = last_id_q;
        burst_cnt_d = burst_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d     = GRANT;
                    grant_id_d  = pick_id;
                    burst_cnt_d = '0;
                end
            end
            GRANT: begin
                if (!req_valid[grant_id_q]) begin
                    state_d   = IDLE;
                    last_id_d = grant_id_q;
                end else if (accept) begin
                    burst_cnt_d = (burst_cnt_q == MaxBurst) ? burst_cnt_q
                                                            : burst_cnt_q + 1'b1;
                    if (burst_cnt_d == MaxBurst) begin
                        state_d   = IDLE;
                        last_id_d = grant_id_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        req_ready            = '0;
        req_ready[grant_id_q] = accept;
        busy                 = (state_q == GRANT);
        grant_id             = grant_id_q;
        fifo_write_enable    = we_q;
        fifo_data_in         = data_q;
    end

    // Write datapath: capture the owner's beat on accept, hold otherwise.
    always_comb begin
        we_d   = accept;
        data_d = accept ? req_data[grant_id_q] : data_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_id_q  <= '0;
            last_id_q   <= LastIdRst;
            burst_cnt_q <= '0;
            we_q        <= 1'b0;
            data_q      <= '0;
        end else begin
            grant_id_q  <= grant_id_d;
            last_id_q   <= last_id_d;
            burst_cnt_q <= burst_cnt_d;
            we_q        <= we_d;
            data_q      <= data_d;
        end
    end

`ifdef FIFO_WRITE_ARBITER_STATS_EN
    logic [15:0] beat_count_q, beat_count_d;

    always_comb begin
        beat_count_d = beat_count_q + {15'd0, we_q};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_count_q <= '0;
        end else begin
            beat_count_q <= beat_count_d;
        end
    end

    assign beat_count = beat_count_q;
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter at the default geometry
// (8-bit words, 4 words per beat, 4 requesters, 4-beat bursts).
module tb_fifo_write_arbiter;
    import fifo_arb_pkg::*;

    localparam int MaxBurst = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [3:0]            req_valid = '0;
    logic [3:0][3:0][7:0]  req_data = '0;
    logic [3:0]            req_ready;
    logic                  fifo_ready = 1'b1;
    beat_t                 fifo_data_in;
    logic                  fifo_write_enable;
    logic [1:0]            grant_id;
    logic                  busy;
`ifdef FIFO_WRITE_ARBITER_STATS_EN
    logic [15:0]           beat_count;
`endif

    int n_vec  = 0;
    int n_fail = 0;

    fifo_write_arbiter #(
        .DATA_WIDTH (8),
        .PAR_WRITE  (4),
        .NUM_REQ    (4),
        .MAX_BURST  (MaxBurst)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .req_valid         (req_valid),
        .req_data          (req_data),
        .req_ready         (req_ready),
        .fifo_ready        (fifo_ready),
        .fifo_data_in      (fifo_data_in),
        .fifo_write_enable (fifo_write_enable),
        .grant_id          (grant_id),
`ifdef FIFO_WRITE_ARBITER_STATS_EN
        .beat_count        (beat_count),
`endif
        .busy              (busy)
    );

    always #5 clk = ~clk;

    // Leaves the bench at a falling edge with reset just released.
    task automatic apply_reset();
        rst        = 1'b0;
        req_valid  = '0;
        fifo_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic randomize_data();
        for (int i = 0; i < 4; i++) req_data[i] = $urandom();
    endtask

    task automatic test_reset();
        rst        = 1'b0;
        req_valid  = 4'b1111;
        fifo_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            randomize_data();
            @(negedge clk);
            #1;
            n_vec++;
            if ({fifo_write_enable, req_ready, busy} !== 6'b0)
                $display("FAIL reset_outputs: got we=%b ready=%b busy=%b want all 0",
                         fifo_write_enable, req_ready, busy);
            n_vec++;
            if (grant_id !== 2'd0 || fifo_data_in !== '0)
                $display("FAIL reset_regs: got grant=%0d data=%h want 0/0", grant_id, fifo_data_in);
            if ({fifo_write_enable, req_ready, busy} !== 6'b0 || grant_id !== 2'd0
                || fifo_data_in !== '0) n_fail++;
        end
    endtask

    task automatic test_single();
        logic [7:0] vals [4];
        logic [1:0] bi;
        logic [3:0] exp_rr;
        logic       exp_we, exp_busy;
        vals[0] = 8'hAA; vals[1] = 8'hFF; vals[2] = 8'h00; vals[3] = 8'h55;
        apply_reset();
        req_valid = 4'b0100;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clk);
            randomize_data();
            bi = (c / 2 > 3) ? 2'd3 : 2'(c / 2);
            req_data[2] = {4{vals[bi]}};
            #1;
            // One IDLE cycle (c=8) separates the first burst from the re-grant.
            exp_rr   = (c % 2 == 1) ? 4'b0100 : 4'b0000;
            exp_we   = (c % 2 == 0) && (c >= 2) && (c <= 8);
            exp_busy = (c >= 1) && (c != 8);
            n_vec++;
            if (req_ready !== exp_rr || fifo_write_enable !== exp_we || busy !== exp_busy) begin
                n_fail++;
                $display("FAIL single_c%0d: got ready=%b we=%b busy=%b want %b %b %b",
                         c, req_ready, fifo_write_enable, busy, exp_rr, exp_we, exp_busy);
            end
            if (exp_we) begin
                bi = 2'((c - 2) / 2);
                n_vec++;
                if (fifo_data_in !== {4{vals[bi]}}) begin
                    n_fail++;
                    $display("FAIL single_data_c%0d: got %h want %h", c, fifo_data_in, {4{vals[bi]}});
                end
            end
            if (exp_busy) begin
                n_vec++;
                if (grant_id !== 2'd2) begin
                    n_fail++;
                    $display("FAIL single_grant_c%0d: got %0d want 2", c, grant_id);
                end
            end
        end
        req_valid = '0;
    endtask

    task automatic test_round_robin();
        beat_t      q[$];
        int         acc = 0;
        logic [1:0] exp_owner;
        logic [3:0] exp_rr;
        apply_reset();
        req_valid = 4'b1111;
        for (int c = 0; c < 200 && acc < 20; c++) begin
            randomize_data();
            #1;
            if (fifo_write_enable) begin
                n_vec++;
                if (q.size() == 0 || fifo_data_in !== q[0]) begin
                    n_fail++;
                    $display("FAIL rr_data: got %h want %h", fifo_data_in,
                             (q.size() != 0) ? q[0] : beat_t'(0));
                end
                if (q.size() != 0) void'(q.pop_front());
            end
            if (req_ready != 4'b0) begin
                exp_owner = 2'(acc / MaxBurst);
                exp_rr    = 4'(1 << exp_owner);
                n_vec++;
                if (req_ready !== exp_rr) begin
                    n_fail++;
                    $display("FAIL rr_order_beat%0d: got ready=%b want %b", acc, req_ready, exp_rr);
                end
                q.push_back(req_data[exp_owner]);
                acc++;
            end
            @(negedge clk);
        end
        n_vec++;
        if (acc != 20) begin
            n_fail++;
            $display("FAIL rr_timeout: got %0d accepts want 20", acc);
        end
        req_valid = '0;
    endtask

    task automatic test_stall();
        int acc = 0, strobes = 0, stall_from = -100, exit_chk = -100;
        bit in_stall;
        apply_reset();
        req_valid = 4'b0010;
        for (int c = 0; c < 30; c++) begin
            req_data[1] = {4{8'(8'h30 + acc)}};
            in_stall    = (c >= stall_from) && (c < stall_from + 5);
            fifo_ready  = !in_stall;
            if (acc >= 4) req_valid = '0;
            #1;
            if (in_stall) begin
                n_vec++;
                if (req_ready !== 4'b0 || fifo_write_enable !== 1'b0 || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stall_hold_c%0d: got ready=%b we=%b busy=%b want 0000 0 1",
                             c, req_ready, fifo_write_enable, busy);
                end
            end
            if (c == stall_from + 5) begin
                n_vec++;
                if (req_ready !== 4'b0010) begin
                    n_fail++;
                    $display("FAIL stall_resume: got ready=%b want 0010", req_ready);
                end
            end
            if (c == exit_chk) begin
                n_vec++;
                if (busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stall_exit: got busy=%b want 0", busy);
                end
            end
            if (fifo_write_enable) begin
                n_vec++;
                if (fifo_data_in !== {4{8'(8'h30 + strobes)}}) begin
                    n_fail++;
                    $display("FAIL stall_data%0d: got %h want %h", strobes, fifo_data_in,
                             {4{8'(8'h30 + strobes)}});
                end
                strobes++;
            end
            if (req_ready[1]) begin
                acc++;
                if (acc == 2) stall_from = c + 2;
                if (acc == 4) exit_chk = c + 1;
            end
            @(negedge clk);
        end
        n_vec++;
        if (acc != 4 || strobes != 4) begin
            n_fail++;
            $display("FAIL stall_count: got accepts=%0d strobes=%0d want 4 4", acc, strobes);
        end

        // Dropping req_valid while stalled releases the grant on the next edge.
        apply_reset();
        req_valid  = 4'b1000;
        fifo_ready = 1'b0;
        @(negedge clk);
        #1;
        n_vec++;
        if (busy !== 1'b1 || grant_id !== 2'd3) begin
            n_fail++;
            $display("FAIL drop_grant: got busy=%b grant=%0d want 1 3", busy, grant_id);
        end
        req_valid = '0;
        @(negedge clk);
        #1;
        n_vec++;
        if (busy !== 1'b0 || fifo_write_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_release: got busy=%b we=%b want 0 0", busy, fifo_write_enable);
        end
        fifo_ready = 1'b1;
    endtask

    task automatic test_reset_mid();
        bit found = 0;
        apply_reset();
        req_valid = 4'b0010;
        randomize_data();
        for (int c = 0; c < 10 && !found; c++) begin
            #1;
            if (req_ready[1]) found = 1;
            else @(negedge clk);
        end
        n_vec++;
        if (!found) begin
            n_fail++;
            $display("FAIL rstmid_accept: got no accept want accept within 10 cycles");
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        n_vec++;
        if (fifo_write_enable !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0
            || fifo_data_in !== '0) begin
            n_fail++;
            $display("FAIL rstmid_async: got we=%b busy=%b ready=%b data=%h want 0",
                     fifo_write_enable, busy, req_ready, fifo_data_in);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            n_vec++;
            if (fifo_write_enable !== 1'b0) begin
                n_fail++;
                $display("FAIL rstmid_strobe: got we=%b want 0", fifo_write_enable);
            end
        end
        req_valid = 4'b0111;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        n_vec++;
        if (busy !== 1'b1 || grant_id !== 2'd0) begin
            n_fail++;
            $display("FAIL rstmid_first_grant: got busy=%b grant=%0d want 1 0", busy, grant_id);
        end
        req_valid = '0;
    endtask

    // Transaction-level reference: owner/last/beat count plus one pending write.
    task automatic test_random();
        logic [1:0] owner, last, cand;
        int         beats;
        bit         m_busy, m_pend, acc, found;
        beat_t      m_data;
        logic [3:0] exp_rr;
        apply_reset();
        owner = 2'd0; last = 2'd3; beats = 0;
        m_busy = 0; m_pend = 0; m_data = '0;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 4) == 0) req_valid[i] = ~req_valid[i];
            fifo_ready = ($urandom_range(0, 3) != 0);
            randomize_data();
            #1;
            acc    = m_busy && req_valid[owner] && fifo_ready && !m_pend;
            exp_rr = acc ? 4'(1 << owner) : 4'b0;
            n_vec++;
            if (req_ready !== exp_rr || fifo_write_enable !== m_pend || busy !== m_busy) begin
                n_fail++;
                $display("FAIL rand_ctrl_c%0d: got ready=%b we=%b busy=%b want %b %b %b",
                         c, req_ready, fifo_write_enable, busy, exp_rr, m_pend, m_busy);
            end
            if (m_pend) begin
                n_vec++;
                if (fifo_data_in !== m_data) begin
                    n_fail++;
                    $display("FAIL rand_data_c%0d: got %h want %h", c, fifo_data_in, m_data);
                end
            end
            if (m_busy) begin
                n_vec++;
                if (grant_id !== owner) begin
                    n_fail++;
                    $display("FAIL rand_grant_c%0d: got %0d want %0d", c, grant_id, owner);
                end
            end
            @(posedge clk);
            if (acc) m_data = req_data[owner];
            m_pend = acc;
            if (!m_busy) begin
                found = 0;
                for (int k = 1; k <= 4; k++) begin
                    cand = 2'(last + k);
                    if (!found && req_valid[cand]) begin
                        found = 1; owner = cand;
                    end
                end
                if (found) begin
                    m_busy = 1; beats = 0;
                end
            end else if (!req_valid[owner]) begin
                m_busy = 0; last = owner;
            end else if (acc) begin
                beats++;
                if (beats >= MaxBurst) begin
                    m_busy = 0; last = owner;
                end
            end
            @(negedge clk);
        end
        req_valid = '0;
    endtask

`ifdef FIFO_WRITE_ARBITER_STATS_EN
    task automatic test_stats();
        int acc = 0;
        apply_reset();
        #1;
        n_vec++;
        if (beat_count !== 16'd0) begin
            n_fail++;
            $display("FAIL stats_reset: got %0d want 0", beat_count);
        end
        req_valid = 4'b0001;
        for (int c = 0; c < 100 && acc < 10; c++) begin
            randomize_data();
            #1;
            if (req_ready[0]) acc++;
            @(negedge clk);
            if (acc >= 10) req_valid = '0;
        end
        req_valid = '0;
        repeat (3) @(negedge clk);
        #1;
        n_vec++;
        if (beat_count !== 16'd10) begin
            n_fail++;
            $display("FAIL stats_count: got %0d want 10", beat_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_reset_mid();
        test_random();
`ifdef FIFO_WRITE_ARBITER_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion want finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fifo_write_arbiter.md
FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of one data word.
REQ-002 Parameter PAR_WRITE, default 4, words per FIFO write beat.
REQ-003 Parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-004 Parameter MAX_BURST, default 4, maximum beats per grant (1..15).
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low (asserted when 0).
REQ-007 req_valid  input  NUM_REQ  per-requester beat available.
REQ-008 req_data  input  [NUM_REQ][PAR_WRITE][DATA_WIDTH]  per-requester beat payload.
REQ-009 req_ready  output  NUM_REQ  per-requester beat accepted this cycle.
REQ-010 fifo_ready  input  1  FIFO can accept one PAR_WRITE beat.
REQ-011 fifo_data_in  output  [PAR_WRITE][DATA_WIDTH]  beat driven to the FIFO.
REQ-012 fifo_write_enable  output  1  one-cycle write strobe to the FIFO.
REQ-013 grant_id  output  $clog2(NUM_REQ)  index of the current owner.
REQ-014 busy  output  1  high while in GRANT state.

Function
REQ-015 FSM states: IDLE, GRANT; no other states.
REQ-016 IDLE: if any req_valid, select winner round-robin starting at (last_id+1) mod NUM_REQ, load grant_id, clear burst_cnt, go to GRANT next cycle.
REQ-017 IDLE with no req_valid: remain in IDLE; grant_id holds.
REQ-018 req_ready[i] = (state==GRANT) & (grant_id==i) & req_valid[i] & fifo_ready & !fifo_write_enable; combinational; all other bits 0.
REQ-019 Accept at edge N (req_valid & req_ready): req_data[grant_id] registered into fifo_data_in; fifo_write_enable high exactly during cycle N+1.
REQ-020 At most one beat in flight; peak throughput one beat per two cycles.
REQ-021 fifo_data_in holds last written value when fifo_write_enable is low.
REQ-022 burst_cnt increments on each accept; saturates at MAX_BURST.
REQ-023 GRANT -> IDLE when accept makes burst_cnt==MAX_BURST, or when req_valid[grant_id] is low; last_id <= grant_id on exit.
REQ-024 fifo_ready low in GRANT: no accept, remain in GRANT, burst_cnt holds (stall, no timeout).
REQ-025 Requester dropping req_valid mid-stall releases the grant on the next edge.
REQ-026 Single requester: re-granted after each exit (one IDLE cycle between bursts).
REQ-027 Payload never modified or reordered; word k of beat maps to fifo_data_in[k].

Reset
REQ-028 rst low: state=IDLE, grant_id=0, last_id=NUM_REQ-1, burst_cnt=0, fifo_write_enable=0, fifo_data_in=0, busy=0, req_ready=0, immediately and asynchronously.
REQ-029 Reset mid-burst: pending write strobe is dropped; no beat is written after rst falls.
REQ-030 After rst releases, first arbitration starts at requester 0.

Configuration
REQ-031 Macro FIFO_WRITE_ARBITER_STATS_EN defined: adds output beat_count (16 bits), incremented on each fifo_write_enable cycle, wraps 0xFFFF->0, reset to 0.
REQ-032 Macro undefined: beat_count port and counter absent; all other behaviour identical.

Structure
REQ-033 Package fifo_arb_pkg holds the FSM state enum (IDLE, GRANT) and the beat typedef (PAR_WRITE x DATA_WIDTH array).
REQ-034 Sub-module rr_picker (combinational round-robin priority select from request vector and last_id) is instantiated once.
REQ-035 Total RTL 120-400 lines including the sub-module.

Verification
REQ-036 Reset: rst=0 with req_valid=4'b1111 -> fifo_write_enable=0, req_ready=0, busy=0 throughout.
REQ-037 Single requester 2 valid 10 cycles, fifo_ready=1, data 0xAA,0xFF,0x00,0x55 -> 4 strobes every 2 cycles, grant_id=2, exit after 4th beat, data exact.
REQ-038 req_valid=4'b1111 steady, MAX_BURST=4 -> grant order 0,1,2,3,0 with 4 beats each.
REQ-039 fifo_ready=0 for 5 cycles mid-burst -> no strobe, burst_cnt holds, resumes on fifo_ready=1 with no beat lost or duplicated.
REQ-040 rst asserted the cycle after an accept -> no fifo_write_enable pulse; after release, grant goes to requester 0.
REQ-041 STATS_EN defined, 10 beats written -> beat_count=10; undefined build compiles without the port.
